// File: rtl/esc_arm_controller.sv
// ESC arming controller: ms prescaler, receiver watchdog, DISARMED/ARMING/ARMED/FAILSAFE
// sequencing and a ramp-limited motor rate, all outputs registered.
module esc_arm_controller #(
    parameter logic [7:0] ARM_LOW_MAX    = 8'd10,
    parameter int         ARM_HOLD_MS    = 1000,
    parameter int         SIG_TIMEOUT_MS = 100,
    parameter logic [7:0] RAMP_STEP      = 8'd4
) (
    input  logic       sys_clk,
    input  logic       resetn,
    input  logic       us_tick_i,
    input  logic [7:0] throttle_val_i,
    input  logic       throttle_valid_i,
    input  logic       arm_req_i,
    output logic [7:0] motor_1_rate_o,
    output logic       armed_o,
    output logic       failsafe_o,
    output logic [1:0] state_dbg_o
);

    localparam logic [1:0]  ST_DISARMED = 2'd0;
    localparam logic [1:0]  ST_ARMING   = 2'd1;
    localparam logic [1:0]  ST_ARMED    = 2'd2;
    localparam logic [1:0]  ST_FAILSAFE = 2'd3;
    localparam logic [9:0]  PRESC_MAX   = 10'd999;
    localparam logic [15:0] HOLD_MS     = 16'(ARM_HOLD_MS);
    localparam logic [15:0] TIMEOUT_MS  = 16'(SIG_TIMEOUT_MS);

    logic [1:0]  state_q, state_d;
    logic [9:0]  presc_q, presc_d;
    logic [15:0] wd_q, wd_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  rate_q, rate_d;
    logic        armed_q, armed_d;
    logic        failsafe_q, failsafe_d;
    logic [1:0]  dbg_q, dbg_d;
    logic        ms_tick_s;
    logic        sig_lost_s;
    logic [8:0]  ramp_sum_s;

    assign sig_lost_s = (wd_q == TIMEOUT_MS);

    // Prescaler, watchdog, throttle target and arming hold counter next-state
    always_comb begin
        presc_d   = presc_q;
        ms_tick_s = 1'b0;
        if (us_tick_i) begin
            if (presc_q == PRESC_MAX) begin
                presc_d   = 10'd0;
                ms_tick_s = 1'b1;
            end else begin
                presc_d = presc_q + 10'd1;
            end
        end else begin
            presc_d = presc_q;
        end

        // A fresh frame beats a coincident timeout-reaching tick
        target_d = target_q;
        wd_d     = wd_q;
        if (throttle_valid_i) begin
            target_d = throttle_val_i;
            wd_d     = 16'd0;
        end else if (ms_tick_s && (wd_q < TIMEOUT_MS)) begin
            wd_d = wd_q + 16'd1;
        end else begin
            wd_d = wd_q;
        end

        hold_d = 16'd0;
        if (state_q == ST_ARMING) begin
            if (ms_tick_s && (hold_q < HOLD_MS)) begin
                hold_d = hold_q + 16'd1;
            end else begin
                hold_d = hold_q;
            end
        end else begin
            hold_d = 16'd0;
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state_q    <= ST_DISARMED;
            presc_q    <= 10'd0;
            wd_q       <= TIMEOUT_MS;
            hold_q     <= 16'd0;
            target_q   <= 8'd0;
            rate_q     <= 8'd0;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b0;
            dbg_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            wd_q       <= wd_d;
            hold_q     <= hold_d;
            target_q   <= target_d;
            rate_q     <= rate_d;
            armed_q    <= armed_d;
            failsafe_q <= failsafe_d;
            dbg_q      <= dbg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISARMED: begin
                if (arm_req_i && !sig_lost_s && (target_q <= ARM_LOW_MAX)) begin
                    state_d = ST_ARMING;
                end else begin
                    state_d = ST_DISARMED;
                end
            end
            ST_ARMING: begin
                if (!arm_req_i || (target_q > ARM_LOW_MAX) || sig_lost_s) begin
                    state_d = ST_DISARMED;
                end else if (hold_q == HOLD_MS) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_ARMING;
                end
            end
            ST_ARMED: begin
                if (sig_lost_s) begin
                    state_d = ST_FAILSAFE;
                end else if (!arm_req_i) begin
                    state_d = ST_DISARMED;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_FAILSAFE: begin
                if (!arm_req_i && !sig_lost_s) begin
                    state_d = ST_DISARMED;
                end else begin
                    state_d = ST_FAILSAFE;
                end
            end
            default: state_d = ST_FAILSAFE;
        endcase
    end

    // Output next-values follow the upcoming state; the ramp sum is 9 bits so 255 cannot wrap
    always_comb begin
        ramp_sum_s = {1'b0, rate_q} + {1'b0, RAMP_STEP};
        rate_d     = 8'd0;
        if ((state_d == ST_ARMED) && (state_q == ST_ARMED)) begin
            if (rate_q > target_q) begin
                rate_d = target_q;
            end else if (ms_tick_s && (rate_q < target_q)) begin
                if (ramp_sum_s > {1'b0, target_q}) begin
                    rate_d = target_q;
                end else begin
                    rate_d = ramp_sum_s[7:0];
                end
            end else begin
                rate_d = rate_q;
            end
        end else begin
            rate_d = 8'd0;
        end
        armed_d    = (state_d == ST_ARMED);
        failsafe_d = (state_d == ST_FAILSAFE);
        dbg_d      = state_d;
    end

    assign motor_1_rate_o = rate_q;
    assign armed_o        = armed_q;
    assign failsafe_o     = failsafe_q;
    assign state_dbg_o    = dbg_q;

endmodule
